// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package decoder_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  typedef logic [1:0] ch_t;

  // Lowest set bit of the mask; used for the first channel of a scan.
  function automatic ch_t lowest_ch(input logic [NUM_CH-1:0] mask);
    ch_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = ch_t'(i);
    end
    return r;
  endfunction

  // True when no set bit lies above cur, i.e. leaving cur wraps the scan.
  function automatic logic wraps_after(input logic [NUM_CH-1:0] mask, input ch_t cur);
    logic above;
    above = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i] && (i > int'(cur))) above = 1'b1;
    end
    return (mask != '0) && !above;
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan client and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; run is a level request, outputs are free-running.
interface decoder_scan_sequencer_if;
  import decoder_scan_pkg::*;

  logic                run;
  logic [NUM_CH-1:0]   mask;
  ch_t                 dec_in;
  logic                dec_en;
  logic                frame_done;
  logic                busy;

  modport master (
    output run, mask,
    input  dec_in, dec_en, frame_done, busy
  );

  modport slave (
    input  run, mask,
    output dec_in, dec_en, frame_done, busy
  );

endinterface

// File: rtl/decoder_scan_sequencer_picker.sv
// Rotating-priority search for the next enabled channel after cur.
// Latency: combinational.
// Backpressure: none.
module next_channel_picker
  import decoder_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  ch_t               cur,
  output ch_t               next,
  output logic              wrap,
  output logic              none
);

  logic hit;
  ch_t  cand;

  // Scan cur+1, cur+2, ... wrapping; cur itself is checked last so a
  // single-channel mask returns to the same channel.
  always_comb begin
    next = cur;
    hit  = 1'b0;
    cand = cur;
    none = (mask == '0);
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ch_t'(int'(cur) + i);
      if (!hit && mask[cand]) begin
        next = cand;
        hit  = 1'b1;
      end
    end
    wrap = !none && (next <= cur);
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Round-robin drive of a 2-to-4 decoder select/enable with dwell and blanking.
// Latency: first channel enabled on the edge that samples run high in IDLE.
// Backpressure: none; run is honoured only at dwell end or during blanking.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int DWELL = 8,
  parameter int BLANK = 1
)
(
  input logic                    clk,
  input logic                    rst,
  decoder_scan_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ch_t              dec_in_q, dec_in_n;
  logic             dec_en_q, dec_en_n;
  logic             fd_q, fd_n;
  logic             busy_q, busy_n;

  ch_t  adv_next;
  logic adv_wrap;
  logic adv_none;
  logic fd_wrap;

  next_channel_picker u_pick (
    .mask (bus.mask),
    .cur  (dec_in_q),
    .next (adv_next),
    .wrap (adv_wrap),
    .none (adv_none)
  );

  // Next state, counter and output values; everything lands in registers.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dec_in_n = dec_in_q;
    dec_en_n = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (bus.run && !adv_none) begin
          state_n  = S_DWELL;
          dec_in_n = lowest_ch(bus.mask);
          dec_en_n = 1'b1;
        end
      end
      S_DWELL: begin
        dec_en_n = 1'b1;
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (!bus.run || adv_none) begin
            state_n  = S_IDLE;
            dec_en_n = 1'b0;
          end else if (BLANK > 0) begin
            state_n  = S_BLANK;
            dec_en_n = 1'b0;
          end else begin
            dec_in_n = adv_next;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BLANK: begin
        if (!bus.run || adv_none) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n  = S_DWELL;
          cnt_n    = '0;
          dec_in_n = adv_next;
          dec_en_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
    // frame_done is registered, so it is armed one edge ahead of the final
    // dwell cycle. With DWELL=1 that edge also switches channel, so the wrap
    // test must look at the incoming channel rather than the current one.
    fd_wrap = (DWELL == 1) ? wraps_after(bus.mask, dec_in_n) : adv_wrap;
    fd_n    = (state_n == S_DWELL) && (cnt_n == DWELL_LAST) && fd_wrap;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dec_in_q <= '0;
      dec_en_q <= 1'b0;
      fd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dec_in_q <= dec_in_n;
      dec_en_q <= dec_en_n;
      fd_q     <= fd_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.dec_in     = dec_in_q;
  assign bus.dec_en     = dec_en_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer with DWELL=3 (BLANK=1 and BLANK=0).
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_decoder_scan_sequencer;
  import decoder_scan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer_if ifa ();
  decoder_scan_sequencer_if ifb ();

  decoder_scan_sequencer #(.DWELL(3), .BLANK(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  decoder_scan_sequencer #(.DWELL(3), .BLANK(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input int t, input int e_in, input int e_en,
                         input int e_fd, input int e_busy);
    check_eq($sformatf("%s_a_dec_in[%0d]", tag, t), int'(ifa.dec_in), e_in);
    check_eq($sformatf("%s_a_dec_en[%0d]", tag, t), int'(ifa.dec_en), e_en);
    check_eq($sformatf("%s_a_frame_done[%0d]", tag, t), int'(ifa.frame_done), e_fd);
    check_eq($sformatf("%s_a_busy[%0d]", tag, t), int'(ifa.busy), e_busy);
  endtask

  task automatic check_b(input string tag, input int t, input int e_in, input int e_en,
                         input int e_fd, input int e_busy);
    check_eq($sformatf("%s_b_dec_in[%0d]", tag, t), int'(ifb.dec_in), e_in);
    check_eq($sformatf("%s_b_dec_en[%0d]", tag, t), int'(ifb.dec_en), e_en);
    check_eq($sformatf("%s_b_frame_done[%0d]", tag, t), int'(ifb.frame_done), e_fd);
    check_eq($sformatf("%s_b_busy[%0d]", tag, t), int'(ifb.busy), e_busy);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected pattern for mask=1111, DWELL=3, BLANK=1, u cycles after start:
  // each channel is 3 enabled cycles then 1 blank, channel 3 wraps.
  task automatic exp_full(input int u, output int ch, output int en, output int fd);
    int ph;
    ph = u % 4;
    ch = (u / 4) % 4;
    en = (ph < 3) ? 1 : 0;
    fd = (ch == 3 && ph == 2) ? 1 : 0;
  endtask

  initial begin
    int ch, en, fd;

    rst      = 1'b1;
    ifa.run  = 1'b0;
    ifa.mask = 4'b0000;
    ifb.run  = 1'b0;
    ifb.mask = 4'b0000;

    // Reset values after two reset cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_a("reset", 0, 0, 0, 0, 0);
    check_b("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Full scan over all four channels.
    ifa.mask = 4'b1111;
    ifa.run  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      exp_full(t, ch, en, fd);
      check_a("full", t, ch, en, fd, 1);
    end

    // Sparse mask: channels 1 and 3 alternate, frame of 8 cycles.
    ifa.run = 1'b0;
    pulse_reset();
    ifa.mask = 4'b1010;
    ifa.run  = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      ch = (((t / 4) % 2) == 1) ? 3 : 1;
      en = ((t % 4) < 3) ? 1 : 0;
      fd = (ch == 3 && (t % 4) == 2) ? 1 : 0;
      check_a("sparse", t, ch, en, fd, 1);
    end

    // Single channel without blanking on the BLANK=0 instance.
    ifa.run = 1'b0;
    pulse_reset();
    ifb.mask = 4'b0100;
    ifb.run  = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      check_b("single", t, 2, 1, ((t % 3) == 2) ? 1 : 0, 1);
    end

    // Run dropped in the first dwell cycle of channel 2.
    ifb.run = 1'b0;
    pulse_reset();
    ifa.mask = 4'b1111;
    ifa.run  = 1'b1;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t <= 10) begin
        exp_full(t, ch, en, fd);
        check_a("rundrop", t, ch, en, fd, 1);
      end else begin
        check_a("rundrop", t, 2, 0, 0, 0);
      end
      if (t == 8) ifa.run = 1'b0;
    end

    // Reset asserted mid-dwell on channel 1, then scanning restarts at 0.
    pulse_reset();
    ifa.mask = 4'b1111;
    ifa.run  = 1'b1;
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      if (t < 6) begin
        exp_full(t, ch, en, fd);
        check_a("rstmid", t, ch, en, fd, 1);
      end else if (t == 6) begin
        check_a("rstmid", t, 0, 0, 0, 0);
      end else begin
        exp_full(t - 7, ch, en, fd);
        check_a("rstmid", t, ch, en, fd, 1);
      end
      if (t == 5) rst = 1'b1;
      if (t == 6) rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
